serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
Word-level sequencer and result collector for the bit-serial adder (serial_adder).
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Clears the adder, streams operands LSB-first on sa_a/sa_b, samples the returned sum bit each cycle, and captures the final carry.
- Presents the (WIDTH+1)-bit parallel result over a valid/ready handshake. It is the parallel-side driver for the serial datapath.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
in_valid  input  1  operand word offered
in_ready  output  1  block can accept a word (high only in IDLE)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in for the word
sa_clr  output  1  synchronous clear of the serial adder carry flop, active-high
sa_a  output  1  serial bit of A, LSB first
sa_b  output  1  serial bit of B, LSB first
sa_cin  output  1  carry-in; equals the word's cin on bit 0 only, else 0
sa_s  input  1  sum bit for the bit currently driven (combinational in the adder)
sa_cout  input  1  carry out of the bit currently driven
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH+1  {carry, sum}; MSB is the final carry
busy  output  1  high in CLR, SHIFT and DONE

Behaviour:
- State encoding: IDLE, CLR, SHIFT, DONE. All flops reset asynchronously when reset=0.
- Reset values:
  - state=IDLE; all sa_* = 0.
  - out_valid=0, out_sum=0, busy=0, bit counter=0.
  - in_ready is a decode of state==IDLE. Any in_valid seen while reset=0 has no effect.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch in_a, in_b, in_cin into shift regs, clear the counter, go to CLR.
- CLR (exactly 1 cycle):
  - sa_clr=1; sa_a=sa_b=sa_cin=0; then go to SHIFT.
- SHIFT (exactly WIDTH cycles, counter k = 0..WIDTH-1):
  - sa_a=A[k], sa_b=B[k]; sa_cin=cin when k==0, else 0.
  - At each edge: out_sum[k] <= sa_s, shift operands right, k++.
  - When k==WIDTH-1: also out_sum[WIDTH] <= sa_cout, go to DONE.
- DONE:
  - out_valid=1; out_sum held stable.
  - On out_ready: go to IDLE, and out_valid drops the next cycle.
  - out_sum keeps its value until the next word's SHIFT overwrites it.
- Latency: handshake accepted at edge 0 → out_valid high after edge WIDTH+1, i.e. WIDTH+2 cycles. Throughput is one word per WIDTH+3 cycles minimum.
- Back-pressure: DONE holds indefinitely; in_ready stays 0 so no new word is accepted.
- sa_* outputs are registered, so there are no glitches on the adder inputs.
- Reset mid-operation: immediate abort to IDLE; the partial result is discarded; no out_valid pulse.
- Overflow: none possible; the WIDTH+1 result always holds A+B+cin.

Decomposition:
- Package serial_add_pkg:
  - state enum (IDLE/CLR/SHIFT/DONE);
  - WIDTH_MIN=2, WIDTH_MAX=32;
  - counter-width function clog2(WIDTH).
- No sub-module required: operand PISO, result SIPO and counter are small enough to live inline.
- The bench pairs this block with the existing serial_adder, wired sa_clr→reset, sa_a→a, sa_b→b, sa_cin→cin, s→sa_s, cout→sa_cout.

Test Plan:
- WIDTH=4, A=1111, B=1101, cin=0 → out_sum=11100 (28). out_valid rises 6 cycles after acceptance; sa_clr high exactly one cycle before the first bit.
- WIDTH=4, A=1111, B=1101, cin=1 → out_sum=11101 (29). sa_cin=1 only during bit 0.
- WIDTH=5, A=11011, B=10001, cin=1 → out_sum=101101 (45). Then a back-to-back word A=0, B=0, cin=0 → out_sum=000000, confirming carry cleared by CLR.
- WIDTH=4, A=1111, B=1111, cin=1 → 11111 (31). Hold out_ready=0 for 5 cycles: out_valid and out_sum stable, in_ready=0, and in_valid pulses are ignored.
- Assert reset=0 at SHIFT bit 2 → all outputs zero at once; after release, word A=0011, B=0001, cin=0 → 00100.
- Random 200 words at WIDTH=8 with random out_ready stalls → out_sum == A+B+cin for every accepted word, with no word lost or duplicated.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial-adder word sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        DONE
    } state_e;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < value) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_add_seq.sv
// Word-level sequencer for a bit-serial adder: clears it, streams operands
// LSB-first on registered outputs, and collects the {carry, sum} result.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             sa_clr,
    output logic             sa_a,
    output logic             sa_b,
    output logic             sa_cin,
    input  logic             sa_s,
    input  logic             sa_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam int unsigned CW = clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             sa_clr_q, sa_clr_d;
    logic             sa_a_q, sa_a_d;
    logic             sa_b_q, sa_b_d;
    logic             sa_cin_q, sa_cin_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // sa_* are computed for the state being entered and registered, so the
    // adder sees bit k for the whole SHIFT cycle that samples its sum.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        sa_clr_d = 1'b0;
        sa_a_d   = 1'b0;
        sa_b_d   = 1'b0;
        sa_cin_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    cin_d    = in_cin;
                    cnt_d    = '0;
                    sa_clr_d = 1'b1;
                    state_d  = CLR;
                end
            end
            CLR: begin
                sa_a_d   = a_q[0];
                sa_b_d   = b_q[0];
                sa_cin_d = cin_q;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                state_d  = SHIFT;
            end
            SHIFT: begin
                sum_d[cnt_q] = sa_s;
                if (last_bit) begin
                    sum_d[WIDTH] = sa_cout;
                    state_d      = DONE;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    sa_a_d = a_q[0];
                    sa_b_d = b_q[0];
                    a_d    = a_q >> 1;
                    b_d    = b_q >> 1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            sa_clr_q <= 1'b0;
            sa_a_q   <= 1'b0;
            sa_b_q   <= 1'b0;
            sa_cin_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            sa_clr_q <= sa_clr_d;
            sa_a_q   <= sa_a_d;
            sa_b_q   <= sa_b_d;
            sa_cin_q <= sa_cin_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign sa_clr    = sa_clr_q;
    assign sa_a      = sa_a_q;
    assign sa_b      = sa_b_q;
    assign sa_cin    = sa_cin_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench: two sequencers (WIDTH 4 and 8), each paired with a
// behavioural serial adder, checked against plain A+B+cin arithmetic.
module tb_serial_add_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       iv4, ir4, ic4, clr4, a4, b4, ci4, s4, co4, ov4, or4, busy4;
    logic [3:0] ia4, ib4;
    logic [4:0] os4;

    logic       iv8, ir8, ic8, clr8, a8, b8, ci8, s8, co8, ov8, or8, busy8;
    logic [7:0] ia8, ib8;
    logic [8:0] os8;

    serial_add_seq #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4),
        .in_a(ia4), .in_b(ib4), .in_cin(ic4),
        .sa_clr(clr4), .sa_a(a4), .sa_b(b4), .sa_cin(ci4),
        .sa_s(s4), .sa_cout(co4),
        .out_valid(ov4), .out_ready(or4), .out_sum(os4), .busy(busy4)
    );

    serial_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .in_a(ia8), .in_b(ib8), .in_cin(ic8),
        .sa_clr(clr8), .sa_a(a8), .sa_b(b8), .sa_cin(ci8),
        .sa_s(s8), .sa_cout(co8),
        .out_valid(ov8), .out_ready(or8), .out_sum(os8), .busy(busy8)
    );

    // Behavioural bit-serial adders: carry flop with synchronous clear.
    logic c4_q = 1'b0, c8_q = 1'b0;
    always @(posedge clk) c4_q <= clr4 ? 1'b0 : co4;
    always @(posedge clk) c8_q <= clr8 ? 1'b0 : co8;
    assign {co4, s4} = 2'(a4) + 2'(b4) + 2'(ci4) + 2'(c4_q);
    assign {co8, s8} = 2'(a8) + 2'(b8) + 2'(ci8) + 2'(c8_q);

    int checks = 0;
    int errors = 0;
    int got8   = 0;
    logic [4:0] q4[$];
    logic [8:0] q8[$];
    bit stall_en8 = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && ov4 && or4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u4_unexpected actual=%0d expected=none", os4);
            end else begin
                check("u4_sum", 64'(os4), 64'(q4.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (reset && ov8 && or8) begin
            got8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u8_unexpected actual=%0d expected=none", os8);
            end else begin
                check("u8_sum", 64'(os8), 64'(q8.pop_front()));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        or8 = stall_en8 ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send4_ready", 64'(ir4), 64'd1);
        iv4 = 1'b1; ia4 = a; ib4 = b; ic4 = c;
        if (push) q4.push_back(5'(a) + 5'(b) + 5'(c));
        @(posedge clk);
        #1 iv4 = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        int n;
        n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send8_ready", 64'(ir8), 64'd1);
        iv8 = 1'b1; ia8 = a; ib8 = b; ic8 = c;
        q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        #1 iv8 = 1'b0;
    endtask

    // Called right after the accepting edge; negedge e follows edge e-1.
    task automatic timing4(input logic c);
        int e;
        bit seen;
        e = 0;
        seen = 1'b0;
        while (!seen && e < 50) begin
            @(negedge clk);
            e++;
            if (e == 1) begin
                check("clr_pulse", 64'(clr4), 64'd1);
                check("cin_in_clr", 64'(ci4), 64'd0);
            end
            if (e == 2) begin
                check("clr_drop", 64'(clr4), 64'd0);
                check("cin_bit0", 64'(ci4), 64'(c));
            end
            if (e == 3) check("cin_bit1", 64'(ci4), 64'd0);
            seen = ov4;
        end
        check("latency", 64'(e), 64'd6);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drained", 64'(q4.size() + q8.size()), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        iv4 = 1'b1; ia4 = 4'hF; ib4 = 4'hF; ic4 = 1'b1; or4 = 1'b1;
        iv8 = 1'b1; ia8 = 8'hFF; ib8 = 8'hFF; ic8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(ir4), 64'd1);
        check("rst_out_valid", 64'(ov4), 64'd0);
        check("rst_out_sum", 64'(os4), 64'd0);
        check("rst_busy", 64'(busy4), 64'd0);
        check("rst_sa", 64'({clr4, a4, b4, ci4}), 64'd0);
        check("rst_u8_busy", 64'(busy8), 64'd0);
        iv4 = 1'b0; iv8 = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'({busy4, busy8, ov4, ov8}), 64'd0);

        send4(4'b1111, 4'b1101, 1'b0, 1'b1);
        timing4(1'b0);
        send4(4'b1111, 4'b1101, 1'b1, 1'b1);
        timing4(1'b1);

        send8(8'd27, 8'd17, 1'b1);
        send8(8'd0, 8'd0, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        send8(8'd0, 8'd0, 1'b0);
        drain(200);

        // Back-pressure: result must hold while out_ready is low.
        or4 = 1'b0;
        send4(4'b1111, 4'b1111, 1'b1, 1'b1);
        n = 0;
        while (!ov4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 64'(ov4), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 iv4 = (i % 2 == 0); ia4 = 4'($urandom); ib4 = 4'($urandom);
            @(negedge clk);
            check("bp_hold_valid", 64'(ov4), 64'd1);
            check("bp_hold_sum", 64'(os4), 64'd31);
            check("bp_in_ready", 64'(ir4), 64'd0);
        end
        @(posedge clk);
        #1 iv4 = 1'b0; or4 = 1'b1;
        drain(50);
        @(negedge clk);
        check("bp_valid_drop", 64'(ov4), 64'd0);

        // Abort mid-SHIFT (bit 2): everything returns to reset values at once.
        send4(4'b1111, 4'b1101, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_busy_before", 64'(busy4), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_outs", 64'({ov4, busy4, clr4, a4, b4, ci4}), 64'd0);
        check("abort_sum", 64'(os4), 64'd0);
        check("abort_in_ready", 64'(ir4), 64'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        send4(4'b0011, 4'b0001, 1'b0, 1'b1);
        drain(50);

        stall_en8 = 1'b1;
        got8 = 0;
        for (int i = 0; i < 200; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain(20000);
        repeat (3) @(negedge clk);
        check("u8_word_count", 64'(got8), 64'd200);
        stall_en8 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
